// File: rtl/mem_arb.sv
// mem_arb: shares the 128-bit main memory beat bus between icache line fills and dcache fills/evicts.
// Build option MEM_ARB_RR_EN: round-robin grant on contention instead of fixed dcache priority.
`timescale 1ns/1ps
module mem_arb #(
  parameter int unsigned AW    = 12,
  parameter int unsigned DW    = 128,
  parameter int unsigned BEATS = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ic_req_valid,
  output logic          ic_req_ready,
  input  logic [AW-1:0] ic_req_addr,
  output logic          ic_rsp_valid,
  output logic [DW-1:0] ic_rsp_data,
  input  logic          dc_req_valid,
  output logic          dc_req_ready,
  input  logic          dc_req_rtype,
  input  logic [AW-1:0] dc_req_addr,
  input  logic [DW-1:0] dc_wdata,
  output logic          dc_wbeat_ack,
  output logic          dc_rsp_valid,
  output logic [DW-1:0] dc_rsp_data,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic          mem_req_we,
  output logic [AW-1:0] mem_req_addr,
  output logic [DW-1:0] mem_req_wdata,
  input  logic          mem_rsp_valid,
  input  logic [DW-1:0] mem_rsp_data
);
  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  localparam int unsigned CW = $clog2(BEATS);
  localparam int unsigned LW = AW - CW;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  if (!is_pow2(BEATS) || BEATS < 2) begin : g_beats_chk
    $error("mem_arb: BEATS must be a power of two >= 2");
  end

  typedef enum logic {DMEM_READ = 1'b0, DMEM_WRITE = 1'b1} dmem_rtype_t;
  typedef enum logic [1:0] {ARB_IDLE, ARB_IC_RD, ARB_DC_RD, ARB_DC_WR} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] iss_cnt_q, iss_cnt_d, rsp_cnt_q, rsp_cnt_d;
  logic          iss_done_q, iss_done_d, rsp_done_q, rsp_done_d;
  logic [LW-1:0] line_q, line_d;
  logic          dc_win, beat_go, rsp_go, stray_c;
  logic          unused_addr_lsb;

  // Beat index replaces the line-offset bits, so those request bits are never looked at.
  assign unused_addr_lsb = ^{ic_req_addr[CW-1:0], dc_req_addr[CW-1:0]};

`ifdef MEM_ARB_RR_EN
  logic last_grant_q, last_grant_d;  // 1 = dcache won the previous handshake
  assign dc_win = dc_req_valid & (~ic_req_valid | ~last_grant_q);
`else
  assign dc_win = dc_req_valid;
`endif

  // Grant, beat issue and response routing; all handshakes are gated off while rst_n is low.
  always_comb begin
    state_d    = state_q;
    iss_cnt_d  = iss_cnt_q;
    iss_done_d = iss_done_q;
    rsp_cnt_d  = rsp_cnt_q;
    rsp_done_d = rsp_done_q;
    line_d     = line_q;
`ifdef MEM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    ic_req_ready  = 1'b0;
    dc_req_ready  = 1'b0;
    ic_rsp_valid  = 1'b0;
    ic_rsp_data   = '0;
    dc_rsp_valid  = 1'b0;
    dc_rsp_data   = '0;
    dc_wbeat_ack  = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = {line_q, iss_cnt_q};
    mem_req_wdata = '0;
    beat_go       = 1'b0;
    rsp_go        = 1'b0;
    stray_c       = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        stray_c = mem_rsp_valid;
        if (rst_n && (dc_win || ic_req_valid)) begin
          iss_cnt_d  = '0;
          iss_done_d = 1'b0;
          rsp_cnt_d  = '0;
          rsp_done_d = 1'b0;
          if (dc_win) begin
            dc_req_ready = 1'b1;
            line_d       = dc_req_addr[AW-1:CW];
            state_d      = (dmem_rtype_t'(dc_req_rtype) == DMEM_WRITE) ? ARB_DC_WR : ARB_DC_RD;
          end else begin
            ic_req_ready = 1'b1;
            line_d       = ic_req_addr[AW-1:CW];
            state_d      = ARB_IC_RD;
          end
`ifdef MEM_ARB_RR_EN
          last_grant_d = dc_win;
`endif
        end
      end
      ARB_DC_WR: begin
        stray_c       = mem_rsp_valid;
        mem_req_valid = rst_n & ~iss_done_q;
        mem_req_we    = 1'b1;
        mem_req_wdata = dc_wdata;
        dc_wbeat_ack  = mem_req_valid & mem_req_ready;
        beat_go       = dc_wbeat_ack;
        if (beat_go && iss_cnt_q == LAST_BEAT) state_d = ARB_IDLE;
      end
      default: begin
        mem_req_valid = rst_n & ~iss_done_q;
        beat_go       = mem_req_valid & mem_req_ready;
        rsp_go        = rst_n & mem_rsp_valid & ~rsp_done_q;
        stray_c       = mem_rsp_valid & rsp_done_q;
        if (state_q == ARB_IC_RD) begin
          ic_rsp_valid = rsp_go;
          ic_rsp_data  = mem_rsp_data;
        end else begin
          dc_rsp_valid = rsp_go;
          dc_rsp_data  = mem_rsp_data;
        end
        if (rsp_go) begin
          rsp_cnt_d = rsp_cnt_q + CW'(1);
          if (rsp_cnt_q == LAST_BEAT) begin
            rsp_done_d = 1'b1;
            state_d    = ARB_IDLE;
          end
        end
      end
    endcase
    if (beat_go) begin
      iss_cnt_d = iss_cnt_q + CW'(1);
      if (iss_cnt_q == LAST_BEAT) iss_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      iss_cnt_q  <= '0;
      iss_done_q <= 1'b0;
      rsp_cnt_q  <= '0;
      rsp_done_q <= 1'b0;
      line_q     <= '0;
    end else begin
      state_q    <= state_d;
      iss_cnt_q  <= iss_cnt_d;
      iss_done_q <= iss_done_d;
      rsp_cnt_q  <= rsp_cnt_d;
      rsp_done_q <= rsp_done_d;
      line_q     <= line_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) last_grant_q <= 1'b0;
    else        last_grant_q <= last_grant_d;
  end
`endif

`ifndef SYNTHESIS
  logic ic_pend_q, ic_pend_d, dc_pend_q, dc_pend_d;

  always_comb begin
    ic_pend_d = rst_n & ic_req_valid & ~ic_req_ready;
    dc_pend_d = rst_n & dc_req_valid & ~dc_req_ready;
  end

  always_ff @(posedge clk) begin
    ic_pend_q <= ic_pend_d;
    dc_pend_q <= dc_pend_d;
  end

  // Requesters must hold valid until ready; unexpected memory responses are dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      a_ic_hold: assert (!ic_pend_q || ic_req_valid) else $error("mem_arb: ic_req_valid dropped before ready");
      a_dc_hold: assert (!dc_pend_q || dc_req_valid) else $error("mem_arb: dc_req_valid dropped before ready");
      a_stray:   assert (!stray_c) else $warning("mem_arb: unexpected mem_rsp_valid dropped");
    end
  end
`endif
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed bench for mem_arb against a small memory model with 2-cycle read latency.
`timescale 1ns/1ps
module tb_mem_arb;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         ic_req_valid, ic_req_ready, ic_rsp_valid;
  logic [11:0]  ic_req_addr;
  logic [127:0] ic_rsp_data;
  logic         dc_req_valid, dc_req_ready, dc_req_rtype, dc_wbeat_ack, dc_rsp_valid;
  logic [11:0]  dc_req_addr;
  logic [127:0] dc_wdata, dc_rsp_data;
  logic         mem_req_valid, mem_req_ready, mem_req_we, mem_rsp_valid;
  logic [11:0]  mem_req_addr;
  logic [127:0] mem_req_wdata, mem_rsp_data;

  always #5 clk = ~clk;

  mem_arb dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
    .ic_rsp_valid(ic_rsp_valid), .ic_rsp_data(ic_rsp_data),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rtype(dc_req_rtype),
    .dc_req_addr(dc_req_addr), .dc_wdata(dc_wdata), .dc_wbeat_ack(dc_wbeat_ack),
    .dc_rsp_valid(dc_rsp_valid), .dc_rsp_data(dc_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  int           n_tests = 0, n_fail = 0, cyc = 0, n_ack = 0, wbase = 0, widx = 0;
  int           exp_w1, exp_dc_n, exp_ic_n;
  bit           toggle = 1'b0, keep_req = 1'b0;
  logic [127:0] mem [4096];
  logic [11:0]  pend_addr[$];
  int           pend_due[$];
  logic [11:0]  beat_addr[$];
  logic         beat_we[$];
  logic [127:0] beat_wdata[$];
  int           beat_cyc[$];
  logic [127:0] ic_got[$], dc_got[$];
  int           grants[$], grant_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_logs();
    beat_addr.delete(); beat_we.delete(); beat_wdata.delete(); beat_cyc.delete();
    ic_got.delete(); dc_got.delete(); grants.delete(); grant_cyc.delete();
    n_ack = 0;
  endtask

  // One clock: log the settled cycle, advance, then drive the memory and dcache side.
  task automatic cycle();
    logic        stall, drop_ic, drop_dc, acked;
    logic [11:0] s_addr;
    logic [127:0] s_wdata;
    #1;
    if (mem_req_valid && mem_req_ready) begin
      beat_addr.push_back(mem_req_addr); beat_we.push_back(mem_req_we);
      beat_wdata.push_back(mem_req_wdata); beat_cyc.push_back(cyc);
      if (mem_req_we) mem[mem_req_addr] = mem_req_wdata;
      else begin pend_addr.push_back(mem_req_addr); pend_due.push_back(cyc + 2); end
    end
    if (ic_rsp_valid) ic_got.push_back(ic_rsp_data);
    if (dc_rsp_valid) dc_got.push_back(dc_rsp_data);
    acked = dc_wbeat_ack;
    if (acked) n_ack++;
    if (ic_req_ready) begin grants.push_back(0); grant_cyc.push_back(cyc); end
    if (dc_req_ready) begin grants.push_back(1); grant_cyc.push_back(cyc); end
    drop_ic = ic_req_ready && !(keep_req && grants.size() < 3);
    drop_dc = dc_req_ready && !(keep_req && grants.size() < 3);
    stall   = rst_n && mem_req_valid && !mem_req_ready;
    s_addr  = mem_req_addr;
    s_wdata = mem_req_wdata;
    @(posedge clk);
    #1;
    cyc++;
    if (drop_ic) ic_req_valid = 1'b0;
    if (drop_dc) dc_req_valid = 1'b0;
    if (acked) begin widx++; dc_wdata = 128'(wbase + widx); end
    mem_req_ready = toggle ? ~mem_req_ready : 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    if (pend_due.size() > 0 && pend_due[0] == cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem[pend_addr[0]];
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    #1;
    if (stall) begin
      chk("stall_valid", 32'(mem_req_valid), 32'd1);
      chk("stall_addr", 32'(mem_req_addr), 32'(s_addr));
      chkd("stall_wdata", mem_req_wdata, s_wdata);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) begin
      mem[12'h124 + i] = 128'hA0 + 128'(i);
      mem[12'h200 + i] = 128'hB0 + 128'(i);
      mem[12'h300 + i] = 128'hC0 + 128'(i);
    end
    rst_n = 1'b0; ic_req_addr = '0; dc_req_addr = '0; dc_req_rtype = 1'b0; dc_wdata = '0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    ic_req_valid = 1'b1; dc_req_valid = 1'b1;

    // Reset: nothing granted or valid even with both requests up
    cycle(); cycle();
    chk("rst_ic_ready", 32'(ic_req_ready), 32'd0);
    chk("rst_dc_ready", 32'(dc_req_ready), 32'd0);
    chk("rst_mem_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_ic_rsp", 32'(ic_rsp_valid), 32'd0);
    chk("rst_dc_rsp", 32'(dc_rsp_valid), 32'd0);
    chk("rst_wack", 32'(dc_wbeat_ack), 32'd0);
    ic_req_valid = 1'b0; dc_req_valid = 1'b0; rst_n = 1'b1;
    cycle();
    clr_logs();

    // Test 1: icache line read of 0x124
    ic_req_addr = 12'h124; ic_req_valid = 1'b1;
    #1;
    chk("t1_ic_ready", 32'(ic_req_ready), 32'd1);
    chk("t1_dc_ready", 32'(dc_req_ready), 32'd0);
    for (int i = 0; i < 30 && ic_got.size() < 4; i++) cycle();
    repeat (3) cycle();
    chk("t1_first_beat_lat", 32'(beat_cyc[0] - grant_cyc[0]), 32'd1);
    chk("t1_nbeats", 32'(beat_addr.size()), 32'd4);
    chk("t1_nrsp", 32'(ic_got.size()), 32'd4);
    chk("t1_dc_rsp", 32'(dc_got.size()), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", 32'(beat_addr[i]), 32'h124 + 32'(i));
      chk("t1_we", 32'(beat_we[i]), 32'd0);
      chkd("t1_data", ic_got[i], 128'hA0 + 128'(i));
    end

    // Test 3: simultaneous ic/dc reads, three contended grants
    clr_logs();
`ifdef MEM_ARB_RR_EN
    exp_w1 = 0; exp_dc_n = 8; exp_ic_n = 8;
`else
    exp_w1 = 1; exp_dc_n = 12; exp_ic_n = 4;
`endif
    ic_req_addr = 12'h200; dc_req_addr = 12'h300; dc_req_rtype = 1'b0;
    keep_req = 1'b1; ic_req_valid = 1'b1; dc_req_valid = 1'b1;
    #1;
    chk("t3_first_dc", 32'(dc_req_ready), 32'd1);
    chk("t3_first_ic", 32'(ic_req_ready), 32'd0);
    for (int i = 0; i < 100 && grants.size() < 3; i++) cycle();
    keep_req = 1'b0;
    for (int i = 0; i < 100 && (ic_got.size() + dc_got.size()) < 16; i++) cycle();
    repeat (3) cycle();
    chk("t3_grant0", 32'(grants[0]), 32'd1);
    chk("t3_grant1", 32'(grants[1]), 32'(exp_w1));
    chk("t3_grant2", 32'(grants[2]), 32'd1);
    chk("t3_grant3", 32'(grants[3]), 32'd0);
    chk("t3_ngrants", 32'(grants.size()), 32'd4);
    chk("t3_dc_n", 32'(dc_got.size()), 32'(exp_dc_n));
    chk("t3_ic_n", 32'(ic_got.size()), 32'(exp_ic_n));
    chkd("t3_dc_data", dc_got[1], 128'hC1);
    chkd("t3_ic_data", ic_got[3], 128'hB3);

    // Test 2: dcache evict to 0x040 with memory stalling every other cycle
    clr_logs();
    dc_req_addr = 12'h042; dc_req_rtype = 1'b1; wbase = 0; widx = 0; dc_wdata = '0;
    mem_req_ready = 1'b0; toggle = 1'b1; dc_req_valid = 1'b1;
    #1;
    chk("t2_dc_ready", 32'(dc_req_ready), 32'd1);
    for (int i = 0; i < 40 && beat_addr.size() < 4; i++) cycle();
    chk("t2_idle_after", 32'(mem_req_valid), 32'd0);
    toggle = 1'b0; mem_req_ready = 1'b1;
    repeat (2) cycle();
    chk("t2_nbeats", 32'(beat_addr.size()), 32'd4);
    chk("t2_nack", 32'(n_ack), 32'd4);
    chk("t2_stall_gap", 32'(beat_cyc[1] - beat_cyc[0]), 32'd2);
    chk("t2_dc_rsp", 32'(dc_got.size()), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("t2_addr", 32'(beat_addr[i]), 32'h040 + 32'(i));
      chk("t2_we", 32'(beat_we[i]), 32'd1);
      chkd("t2_wdata", beat_wdata[i], 128'(i));
    end

    // Test 4: evict then refill the same line
    clr_logs();
    dc_req_addr = 12'h040; dc_req_rtype = 1'b1; wbase = 16; widx = 0; dc_wdata = 128'd16;
    dc_req_valid = 1'b1;
    #1;
    chk("t4_wr_ready", 32'(dc_req_ready), 32'd1);
    for (int i = 0; i < 40 && beat_addr.size() < 4; i++) cycle();
    dc_req_rtype = 1'b0; dc_req_valid = 1'b1;
    #1;
    chk("t4_rd_ready", 32'(dc_req_ready), 32'd1);
    chk("t4_gap", 32'(cyc - beat_cyc[3]), 32'd1);
    for (int i = 0; i < 30 && dc_got.size() < 4; i++) cycle();
    repeat (2) cycle();
    chk("t4_nbeats", 32'(beat_addr.size()), 32'd8);
    chk("t4_rd_after_wr", 32'(beat_cyc[4] - beat_cyc[3]), 32'd2);
    chk("t4_ic_rsp", 32'(ic_got.size()), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("t4_rd_addr", 32'(beat_addr[4 + i]), 32'h040 + 32'(i));
      chk("t4_rd_we", 32'(beat_we[4 + i]), 32'd0);
      chkd("t4_rd_data", dc_got[i], 128'h10 + 128'(i));
    end

    // Test 5: reset during the second response of an icache read
    clr_logs();
    ic_req_addr = 12'h124; ic_req_valid = 1'b1;
    for (int i = 0; i < 30 && ic_got.size() < 1; i++) cycle();
    rst_n = 1'b0;
    #1;
    chk("t5_rsp_gated", 32'(ic_rsp_valid), 32'd0);
    chk("t5_mem_gated", 32'(mem_req_valid), 32'd0);
    cycle();
    rst_n = 1'b1;
    #1;
    chk("t5_idle_valid", 32'(mem_req_valid), 32'd0);
    chk("t5_late_rsp", 32'(ic_rsp_valid), 32'd0);
    chk("t5_no_ready", 32'(ic_req_ready), 32'd0);
    repeat (3) cycle();
    chk("t5_ic_n", 32'(ic_got.size()), 32'd1);
    chk("t5_nbeats", 32'(beat_addr.size()), 32'd3);
    dc_req_addr = 12'h124; dc_req_rtype = 1'b0; dc_req_valid = 1'b1;
    #1;
    chk("t5_dc_ready", 32'(dc_req_ready), 32'd1);
    for (int i = 0; i < 30 && dc_got.size() < 4; i++) cycle();
    repeat (2) cycle();
    chk("t5_dc_n", 32'(dc_got.size()), 32'd4);
    chk("t5_ic_n_after", 32'(ic_got.size()), 32'd1);
    chkd("t5_dc_data0", dc_got[0], 128'hA0);
    chkd("t5_dc_data3", dc_got[3], 128'hA3);

    // Test 6: stray memory response while idle
    clr_logs();
    mem_rsp_valid = 1'b1; mem_rsp_data = 128'hDEAD;
    #1;
    chk("t6_ic_rsp", 32'(ic_rsp_valid), 32'd0);
    chk("t6_dc_rsp", 32'(dc_rsp_valid), 32'd0);
    cycle();
    ic_req_addr = 12'h124; ic_req_valid = 1'b1;
    #1;
    chk("t6_still_idle", 32'(ic_req_ready), 32'd1);
    for (int i = 0; i < 30 && ic_got.size() < 4; i++) cycle();
    repeat (2) cycle();
    chk("t6_ic_n", 32'(ic_got.size()), 32'd4);
    chkd("t6_ic_data0", ic_got[0], 128'hA0);
    chk("t6_dc_n", 32'(dc_got.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
